// File: rtl/uart_click_tx.sv
// uart_click_tx: debounces a push-button and sends one fixed 8N1 UART byte per
// click. Clicks that arrive while a frame is on the line wait in a saturating
// counter.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn_in     raw button, asynchronous to clk, active-high
//   send_req   1-cycle synchronous click request, bypasses sync and debounce
//   tx_out     UART serial line, idles high (registered)
//   busy       high while a frame is in progress (registered)
//   frame_done 1-cycle pulse on the last stop-bit cycle (registered)
//   pending    number of queued, unsent clicks
`timescale 1ns/1ps

module uart_click_tx #(
  parameter int unsigned CLK_FREQ        = 65_000_000,
  parameter int unsigned BAUD            = 115_200,
  parameter logic [7:0]  CLICK_BYTE      = 8'h43,
  parameter int unsigned DEBOUNCE_CYCLES = 650_000,
  parameter int unsigned PEND_MAX        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn_in,
  input  logic                              send_req,
  output logic                              tx_out,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(PEND_MAX+1)-1:0]     pending
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W     = $clog2(BIT_CYCLES + 1);
  localparam int unsigned DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PEND_W     = $clog2(PEND_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_cnt_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [7:0]          shift_q, shift_nxt;
  logic                sync1, sync2;
  logic                deb_level;
  logic [DEB_W-1:0]    deb_cnt;
  logic                tx_c, done_c;
  logic                deb_flip_c, click_c, frame_start_c, bit_end_c;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  assign deb_flip_c = (sync2 != deb_level) && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (sync2 == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_flip_c) begin
      deb_level <= ~deb_level;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + DEB_W'(1);
    end
  end

  // A press (debounced rise) and a soft request in the same cycle are one click
  assign click_c       = (deb_flip_c && !deb_level) || send_req;
  assign frame_start_c = (state == IDLE) && (pending != '0);

  // Click queue: saturating, net zero when a click coincides with a frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (click_c && !frame_start_c) begin
      if (pending != PEND_W'(PEND_MAX)) pending <= pending + PEND_W'(1);
    end else if (frame_start_c && !click_c) begin
      pending <= pending - PEND_W'(1);
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift_q  <= shift_nxt;
    end
  end

  assign bit_end_c = (baud_cnt == BAUD_W'(BIT_CYCLES - 1));

  // Next-state, baud/bit counters and line value for the current state
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_q;
    tx_c         = 1'b1;
    done_c       = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (frame_start_c) begin
          state_nxt   = START;
          shift_nxt   = CLICK_BYTE;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        tx_c = 1'b0;
        if (bit_end_c) begin
          baud_cnt_nxt = '0;
          state_nxt    = DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_c = shift_q[0];
        if (bit_end_c) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {1'b0, shift_q[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          done_c       = 1'b1;
          baud_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: line and status follow the state one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_out     <= tx_c;
      busy       <= (state != IDLE);
      frame_done <= done_c;
    end
  end

endmodule

// File: tb/tb_uart_click_tx.sv
// Testbench for uart_click_tx: directed scenarios plus randomized button and
// soft-request traffic, checked every cycle against a frame-level model.
`timescale 1ns/1ps

module tb_uart_click_tx;

  localparam int unsigned BITC = 10;
  localparam int unsigned DEB  = 4;
  localparam int unsigned PMAX = 3;
  localparam int unsigned FLEN = 10 * BITC;
  localparam logic [7:0]  BYTE = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       send_req = 1'b0;
  logic       tx_out, busy, frame_done;
  logic [1:0] pending;

  always #5 clk = ~clk;

  uart_click_tx #(
    .CLK_FREQ(1000), .BAUD(100), .CLICK_BYTE(BYTE),
    .DEBOUNCE_CYCLES(DEB), .PEND_MAX(PMAX)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .send_req(send_req),
    .tx_out(tx_out), .busy(busy), .frame_done(frame_done), .pending(pending)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame view: once a frame starts, line bit i (0=start, 1..8 data, 9=stop)
  // is shown for BITC cycles; outputs appear one cycle after the state.
  bit m_s1 = 0, m_s2 = 0, m_deb = 0;
  int m_run = 0;
  int m_pend = 0;
  bit m_active = 0;
  int m_k = 0;
  logic e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  int e_pend = 0;

  function automatic logic frame_bit(int b);
    logic [7:0] v;
    v = BYTE;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[3'(b - 1)];
  endfunction

  task automatic model_step();
    bit rise, start, click;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
      m_pend = 0; m_active = 0; m_k = 0;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_pend = 0;
      return;
    end
    rise = 0;
    if (m_s2 != m_deb) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_deb = m_s2;
        m_run = 0;
        rise  = m_s2;
      end
    end else begin
      m_run = 0;
    end
    start = !m_active && (m_pend != 0);
    click = rise || (send_req === 1'b1);
    if (m_active) begin
      e_tx   = frame_bit(m_k / int'(BITC));
      e_busy = 1'b1;
      e_done = (m_k == int'(FLEN) - 1);
      if (m_k == int'(FLEN) - 1) m_active = 0;
      else m_k++;
    end else begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (start) begin
        m_active = 1;
        m_k = 0;
      end
    end
    if (click && !start) begin
      if (m_pend < int'(PMAX)) m_pend++;
    end else if (start && !click) begin
      m_pend--;
    end
    e_pend = m_pend;
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int dut_frames = 0;
  int max_pend = 0;
  int stamps[$];

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("tx_out",     32'(tx_out),     32'(e_tx));
      check("busy",       32'(busy),       32'(e_busy));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("pending",    32'(pending),    32'(e_pend));
      if (frame_done === 1'b1) begin
        dut_frames++;
        stamps.push_back(cyc);
      end
      if (int'(pending) > max_pend) max_pend = int'(pending);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
  endtask

  initial begin
    int f0;
    int hold;
    int n;
    logic [9:0] pat;
    pat = 10'b1101001010;

    // 1. reset
    repeat (3) tick();
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b1;
    repeat (100) tick();
    check("idle_tx", 32'(tx_out), 32'd1);
    check("idle_frames", 32'(dut_frames), 32'd0);

    // 2. single send_req: literal frame shape
    f0 = dut_frames;
    pulse_req();
    check("req_pending", 32'(pending), 32'd1);
    for (int off = 1; off <= 102; off++) begin
      tick();
      if (off == 1) begin
        check("pre_start_tx", 32'(tx_out), 32'd1);
        check("pre_start_busy", 32'(busy), 32'd0);
      end
      if (off >= 2 && off <= 101 && ((off - 2) % 10) == 5)
        check("frame_bit", 32'(tx_out), 32'(pat[(off - 2) / 10]));
      if (off == 100) check("done_early", 32'(frame_done), 32'd0);
      if (off == 101) check("done_pulse", 32'(frame_done), 32'd1);
      if (off == 102) begin
        check("post_busy", 32'(busy), 32'd0);
        check("post_tx", 32'(tx_out), 32'd1);
      end
    end
    check("single_frames", 32'(dut_frames), 32'(f0 + 1));

    // 3. debounce
    f0 = dut_frames;
    btn_in = 1'b1;
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (20) tick();
    check("glitch_pending", 32'(pending), 32'd0);
    check("glitch_frames", 32'(dut_frames), 32'(f0));
    btn_in = 1'b1;
    repeat (20) tick();
    btn_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (2) tick();
      btn_in = 1'b1;
      tick();
      btn_in = 1'b0;
    end
    repeat (200) tick();
    check("press_frames", 32'(dut_frames), 32'(f0 + 1));

    // 4. queueing and saturation
    f0 = dut_frames;
    max_pend = 0;
    pulse_req();
    repeat (10) tick();
    for (int i = 0; i < 5; i++) begin
      pulse_req();
      repeat (2) tick();
    end
    repeat (450) tick();
    check("queue_frames", 32'(dut_frames), 32'(f0 + 4));
    check("queue_max", 32'(max_pend), 32'd3);
    n = stamps.size();
    for (int i = n - 3; i < n; i++)
      if (i >= 1) check("frame_spacing", 32'(stamps[i] - stamps[i - 1]), 32'd101);

    // 5a. send_req coincident with debounced rise
    f0 = dut_frames;
    btn_in = 1'b1;
    repeat (5) tick();
    pulse_req();
    check("coinc_pending", 32'(pending), 32'd1);
    repeat (150) tick();
    btn_in = 1'b0;
    repeat (20) tick();
    check("coinc_frames", 32'(dut_frames), 32'(f0 + 1));

    // 5b. send_req during the frame-start cycle
    f0 = dut_frames;
    send_req = 1'b1;
    tick();
    tick();
    send_req = 1'b0;
    check("start_coinc_pending", 32'(pending), 32'd1);
    repeat (260) tick();
    check("start_coinc_frames", 32'(dut_frames), 32'(f0 + 2));

    // 6. async reset mid-DATA
    f0 = dut_frames;
    pulse_req();
    repeat (3) tick();
    pulse_req();
    repeat (51) tick();
    check("pre_reset_tx", 32'(tx_out), 32'd0);
    check("pre_reset_pending", 32'(pending), 32'd1);
    rst = 1'b0;
    #1;
    check("async_tx", 32'(tx_out), 32'd1);
    check("async_pending", 32'(pending), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (150) tick();
    check("no_resume_frames", 32'(dut_frames), 32'(f0));
    check("no_resume_tx", 32'(tx_out), 32'd1);

    // 7. randomized traffic with one reset in the middle
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        btn_in = ~btn_in;
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      send_req = ($urandom_range(0, 49) == 0);
      if (i == 2000) rst = 1'b0;
      if (i == 2002) rst = 1'b1;
      tick();
    end
    send_req = 1'b0;
    btn_in = 1'b0;
    repeat (500) tick();
    check("final_idle_busy", 32'(busy), 32'd0);
    check("final_idle_pending", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
